// File: rtl/cndm_micro_rx_desc_fetch.sv
// ---------------------------------------------------------------------------
// cndm_micro_rx_desc_fetch
//
// RX descriptor fetch stage for the Corundum-micro datapath. Each desc_req
// pulse fetches one 16-byte descriptor from the host ring through the DMA
// read engine and presents it on axis_desc. tuser[0]=1 means "no descriptor"
// (queue disabled, ring empty, or DMA error) and carries all-zero tdata.
//
// The DMA engine deposits the descriptor through the segmented RAM write
// port. Only local bytes 0..15 (the descriptor buffer) are kept; all other
// writes are accepted and dropped.
//
// Optional build macro:
//   CNDM_DESC_FETCH_STATS_EN - adds saturating stat_empty_cnt_o and
//                              stat_err_cnt_o fail counters.
// ---------------------------------------------------------------------------
module cndm_micro_rx_desc_fetch #(
    parameter int ADDR_W     = 64,
    parameter int RAM_ADDR_W = 16,
    parameter int PTR_W      = 16,
    parameter int LEN_W      = 16,
    parameter int SEGS       = 2,
    parameter int SEG_DATA_W = 64,
    parameter int SEG_BE_W   = SEG_DATA_W / 8,
    parameter int SEG_ADDR_W = RAM_ADDR_W - $clog2(SEGS * SEG_BE_W)
) (
    input  logic                       clk,
    input  logic                       rst_n,

    // fetch request
    input  logic                       desc_req_i,

    // descriptor output stream
    output logic [127:0]               axis_desc_tdata_o,
    output logic                       axis_desc_tvalid_o,
    input  logic                       axis_desc_tready_i,
    output logic                       axis_desc_tlast_o,
    output logic [0:0]                 axis_desc_tuser_o,

    // DMA read request (host -> local)
    output logic [ADDR_W-1:0]          dma_rd_desc_req_src_addr_o,
    output logic [RAM_ADDR_W-1:0]      dma_rd_desc_req_dst_addr_o,
    output logic [LEN_W-1:0]           dma_rd_desc_req_len_o,
    output logic [0:0]                 dma_rd_desc_req_tag_o,
    output logic                       dma_rd_desc_req_valid_o,
    input  logic                       dma_rd_desc_req_ready_i,

    // DMA read status
    input  logic [0:0]                 dma_rd_desc_sts_tag_i,
    input  logic [3:0]                 dma_rd_desc_sts_error_i,
    input  logic                       dma_rd_desc_sts_valid_i,

    // local RAM write port, driven by the DMA engine
    input  logic [SEGS*SEG_BE_W-1:0]   dma_ram_wr_cmd_be_i,
    input  logic [SEGS*SEG_ADDR_W-1:0] dma_ram_wr_cmd_addr_i,
    input  logic [SEGS*SEG_DATA_W-1:0] dma_ram_wr_cmd_data_i,
    input  logic [SEGS-1:0]            dma_ram_wr_cmd_valid_i,
    output logic [SEGS-1:0]            dma_ram_wr_cmd_ready_o,
    output logic [SEGS-1:0]            dma_ram_wr_done_o,

    // queue control
    input  logic                       enable_i,
    input  logic [ADDR_W-1:0]          ring_base_i,
    input  logic [3:0]                 ring_log_size_i,
    input  logic [PTR_W-1:0]           prod_ptr_i,
    output logic [PTR_W-1:0]           cons_ptr_o
`ifdef CNDM_DESC_FETCH_STATS_EN
    ,
    output logic [31:0]                stat_empty_cnt_o,
    output logic [31:0]                stat_err_cnt_o
`endif
);

    // Byte offset width of one full RAM word (all segments side by side).
    localparam int WORD_SHIFT = $clog2(SEGS * SEG_BE_W);

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_DMA_REQ  = 2'd1;
    localparam logic [1:0] ST_DMA_WAIT = 2'd2;
    localparam logic [1:0] ST_OUTPUT   = 2'd3;

    // -----------------------------------------------------------------------
    // Reset: asynchronous assertion, synchronous release
    // -----------------------------------------------------------------------
    logic [1:0] rst_sync_q;
    logic       rst_int_n;

    // Two-flop release synchroniser; assertion propagates immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync_q <= 2'b00;
        end else begin
            // NOTE: sequential state always uses non-blocking assignment so
            // every flop samples pre-edge values regardless of statement order.
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign rst_int_n = rst_sync_q[1];

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [1:0]        state_q,        state_d;
    logic              pending_q,      pending_d;
    logic [PTR_W-1:0]  cons_ptr_q,     cons_ptr_d;
    logic              tvalid_q,       tvalid_d;
    logic [127:0]      tdata_q,        tdata_d;
    logic              tuser_q,        tuser_d;
    logic              req_valid_q,    req_valid_d;
    logic [ADDR_W-1:0] req_src_addr_q, req_src_addr_d;
    logic [SEGS-1:0]   wr_ready_q;
    logic [SEGS-1:0]   wr_done_q;
    logic [127:0]      desc_buf_q,     desc_buf_d;

    logic              ring_empty;
    logic [PTR_W-1:0]  ring_mask;
    logic [PTR_W-1:0]  ring_index;
    logic [SEGS-1:0]   wr_accept;
    logic [RAM_ADDR_W-1:0] byte_addr;

    assign ring_empty = (prod_ptr_i == cons_ptr_q);
    assign ring_mask  = (PTR_W'(1) << ring_log_size_i) - PTR_W'(1);
    assign ring_index = cons_ptr_q & ring_mask;
    assign wr_accept  = dma_ram_wr_cmd_valid_i & wr_ready_q;

    // The status tag is always 0 (single outstanding read), so it is unused.
    logic unused_sts_tag;
    assign unused_sts_tag = ^dma_rd_desc_sts_tag_i;

    // -----------------------------------------------------------------------
    // Descriptor buffer merge: byte-enable write of bytes 0..15 only
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can
        // leave it unassigned and infer a latch.
        desc_buf_d = desc_buf_q;
        byte_addr  = '0;
        for (int s = 0; s < SEGS; s++) begin
            for (int b = 0; b < SEG_BE_W; b++) begin
                byte_addr = (RAM_ADDR_W'(dma_ram_wr_cmd_addr_i[s*SEG_ADDR_W +: SEG_ADDR_W])
                             << WORD_SHIFT) + RAM_ADDR_W'(s * SEG_BE_W + b);
                if (wr_accept[s] && dma_ram_wr_cmd_be_i[s*SEG_BE_W + b] &&
                    (byte_addr < RAM_ADDR_W'(16))) begin
                    desc_buf_d[byte_addr[3:0]*8 +: 8] =
                        dma_ram_wr_cmd_data_i[(s*SEG_BE_W + b)*8 +: 8];
                end
            end
        end
    end

    // Descriptor buffer storage.
    always_ff @(posedge clk) begin
        // NOTE: pure data storage is left without reset; its contents are
        // only forwarded after a DMA completion has overwritten them.
        desc_buf_q <= desc_buf_d;
    end

    // RAM write port handshake: always ready after reset, done one cycle
    // after each accepted beat.
    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            wr_ready_q <= '0;
            wr_done_q  <= '0;
        end else begin
            wr_ready_q <= '1;
            wr_done_q  <= wr_accept;
        end
    end

    // -----------------------------------------------------------------------
    // Fetch FSM next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d        = state_q;
        pending_d      = pending_q | desc_req_i;
        cons_ptr_d     = cons_ptr_q;
        tvalid_d       = tvalid_q;
        tdata_d        = tdata_q;
        tuser_d        = tuser_q;
        req_valid_d    = req_valid_q;
        req_src_addr_d = req_src_addr_q;

        case (state_q)
            ST_IDLE: begin
                if (pending_q) begin
                    if (!enable_i || ring_empty) begin
                        tuser_d  = 1'b1;
                        tdata_d  = '0;
                        tvalid_d = 1'b1;
                        state_d  = ST_OUTPUT;
                    end else begin
                        // Base and ring size are captured here; later
                        // changes only affect the next fetch.
                        req_src_addr_d = ring_base_i + (ADDR_W'(ring_index) << 4);
                        req_valid_d    = 1'b1;
                        state_d        = ST_DMA_REQ;
                    end
                end
            end

            ST_DMA_REQ: begin
                if (dma_rd_desc_req_ready_i) begin
                    req_valid_d = 1'b0;
                    state_d     = ST_DMA_WAIT;
                end
            end

            ST_DMA_WAIT: begin
                if (dma_rd_desc_sts_valid_i) begin
                    if (dma_rd_desc_sts_error_i != 4'd0) begin
                        tuser_d = 1'b1;
                        tdata_d = '0;
                    end else begin
                        tuser_d    = 1'b0;
                        tdata_d    = desc_buf_q;
                        cons_ptr_d = cons_ptr_q + PTR_W'(1);
                    end
                    tvalid_d = 1'b1;
                    state_d  = ST_OUTPUT;
                end
            end

            ST_OUTPUT: begin
                if (axis_desc_tready_i) begin
                    tvalid_d  = 1'b0;
                    pending_d = 1'b0;
                    state_d   = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Fetch FSM and output registers.
    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state_q        <= ST_IDLE;
            pending_q      <= 1'b0;
            cons_ptr_q     <= '0;
            tvalid_q       <= 1'b0;
            tdata_q        <= '0;
            tuser_q        <= 1'b0;
            req_valid_q    <= 1'b0;
            req_src_addr_q <= '0;
        end else begin
            state_q        <= state_d;
            pending_q      <= pending_d;
            cons_ptr_q     <= cons_ptr_d;
            tvalid_q       <= tvalid_d;
            tdata_q        <= tdata_d;
            tuser_q        <= tuser_d;
            req_valid_q    <= req_valid_d;
            req_src_addr_q <= req_src_addr_d;
        end
    end

`ifdef CNDM_DESC_FETCH_STATS_EN
    // -----------------------------------------------------------------------
    // Fail statistics, counted on entry to OUTPUT
    // -----------------------------------------------------------------------
    logic [31:0] stat_empty_cnt_q;
    logic [31:0] stat_err_cnt_q;

    // Saturating counters for empty/disabled fails and DMA-error fails.
    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            stat_empty_cnt_q <= '0;
            stat_err_cnt_q   <= '0;
        end else begin
            if ((state_q == ST_IDLE) && (state_d == ST_OUTPUT) &&
                (stat_empty_cnt_q != '1)) begin
                stat_empty_cnt_q <= stat_empty_cnt_q + 32'd1;
            end
            if ((state_q == ST_DMA_WAIT) && (state_d == ST_OUTPUT) && tuser_d &&
                (stat_err_cnt_q != '1)) begin
                stat_err_cnt_q <= stat_err_cnt_q + 32'd1;
            end
        end
    end

    assign stat_empty_cnt_o = stat_empty_cnt_q;
    assign stat_err_cnt_o   = stat_err_cnt_q;
`endif

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign axis_desc_tdata_o  = tdata_q;
    assign axis_desc_tvalid_o = tvalid_q;
    assign axis_desc_tlast_o  = 1'b1;
    assign axis_desc_tuser_o  = tuser_q;

    assign dma_rd_desc_req_src_addr_o = req_src_addr_q;
    assign dma_rd_desc_req_dst_addr_o = '0;
    assign dma_rd_desc_req_len_o      = LEN_W'(16);
    assign dma_rd_desc_req_tag_o      = 1'b0;
    assign dma_rd_desc_req_valid_o    = req_valid_q;

    assign dma_ram_wr_cmd_ready_o = wr_ready_q;
    assign dma_ram_wr_done_o      = wr_done_q;

    assign cons_ptr_o = cons_ptr_q;

endmodule

// File: tb/tb_cndm_micro_rx_desc_fetch.sv
// ---------------------------------------------------------------------------
// Testbench for cndm_micro_rx_desc_fetch: directed fetch sequences against a
// small in-bench DMA engine model. Pointers are 4 bits wide here.
// ---------------------------------------------------------------------------
module tb_cndm_micro_rx_desc_fetch;

    localparam int PTR_W = 4;
    localparam logic [63:0] BASE = 64'h0000_0000_1000_0000;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          desc_req = 1'b0;
    logic [127:0]  tdata;
    logic          tvalid;
    logic          tready = 1'b0;
    logic          tlast;
    logic [0:0]    tuser;
    logic [63:0]   req_src;
    logic [15:0]   req_dst;
    logic [15:0]   req_len;
    logic [0:0]    req_tag;
    logic          req_valid;
    logic          req_ready = 1'b0;
    logic [0:0]    sts_tag = 1'b0;
    logic [3:0]    sts_error = 4'd0;
    logic          sts_valid = 1'b0;
    logic [15:0]   wr_be = '0;
    logic [23:0]   wr_addr = '0;
    logic [127:0]  wr_data = '0;
    logic [1:0]    wr_valid = '0;
    logic [1:0]    wr_ready;
    logic [1:0]    wr_done;
    logic          enable = 1'b1;
    logic [63:0]   ring_base = '0;
    logic [3:0]    ring_log_size = 4'd0;
    logic [PTR_W-1:0] prod_ptr = '0;
    logic [PTR_W-1:0] cons_ptr;
`ifdef CNDM_DESC_FETCH_STATS_EN
    logic [31:0]   stat_empty_cnt;
    logic [31:0]   stat_err_cnt;
`endif

    int n_checks = 0;
    int n_pass   = 0;
    logic [PTR_W-1:0] exp_cons = '0;

    cndm_micro_rx_desc_fetch #(
        .PTR_W (PTR_W)
    ) dut (
        .clk                        (clk),
        .rst_n                      (rst_n),
        .desc_req_i                 (desc_req),
        .axis_desc_tdata_o          (tdata),
        .axis_desc_tvalid_o         (tvalid),
        .axis_desc_tready_i         (tready),
        .axis_desc_tlast_o          (tlast),
        .axis_desc_tuser_o          (tuser),
        .dma_rd_desc_req_src_addr_o (req_src),
        .dma_rd_desc_req_dst_addr_o (req_dst),
        .dma_rd_desc_req_len_o      (req_len),
        .dma_rd_desc_req_tag_o      (req_tag),
        .dma_rd_desc_req_valid_o    (req_valid),
        .dma_rd_desc_req_ready_i    (req_ready),
        .dma_rd_desc_sts_tag_i      (sts_tag),
        .dma_rd_desc_sts_error_i    (sts_error),
        .dma_rd_desc_sts_valid_i    (sts_valid),
        .dma_ram_wr_cmd_be_i        (wr_be),
        .dma_ram_wr_cmd_addr_i      (wr_addr),
        .dma_ram_wr_cmd_data_i      (wr_data),
        .dma_ram_wr_cmd_valid_i     (wr_valid),
        .dma_ram_wr_cmd_ready_o     (wr_ready),
        .dma_ram_wr_done_o          (wr_done),
        .enable_i                   (enable),
        .ring_base_i                (ring_base),
        .ring_log_size_i            (ring_log_size),
        .prod_ptr_i                 (prod_ptr),
        .cons_ptr_o                 (cons_ptr)
`ifdef CNDM_DESC_FETCH_STATS_EN
        ,
        .stat_empty_cnt_o           (stat_empty_cnt),
        .stat_err_cnt_o             (stat_err_cnt)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish, got timeout expected completion");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    endtask

    // Request that must fail with "no descriptor" two cycles after desc_req.
    task automatic do_empty_fail(input string tag);
        desc_req = 1'b1;
        @(negedge clk);
        desc_req = 1'b0;
        check({tag, " tvalid early"}, tvalid, 1'b0);
        @(negedge clk);
        check({tag, " tvalid"}, tvalid, 1'b1);
        check({tag, " tuser"}, tuser, 1'b1);
        check({tag, " tdata"}, tdata, 128'd0);
        check({tag, " no dma req"}, req_valid, 1'b0);
        tready = 1'b1;
        @(negedge clk);
        tready = 1'b0;
        check({tag, " tvalid drop"}, tvalid, 1'b0);
        check({tag, " cons_ptr"}, cons_ptr, exp_cons);
    endtask

    // Wait (bounded) for the DMA read request and accept it.
    task automatic accept_req(input string tag, input logic [63:0] exp_src, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            if (req_valid) ok = 1'b1;
            else @(negedge clk);
        end
        check({tag, " req seen"}, ok, 1'b1);
        if (ok) begin
            check({tag, " src_addr"}, req_src, exp_src);
            check({tag, " len"}, req_len, 16'd16);
            check({tag, " dst/tag"}, {req_dst, req_tag}, 17'd0);
            req_ready = 1'b1;
            @(negedge clk);
            req_ready = 1'b0;
            check({tag, " req drop"}, req_valid, 1'b0);
        end
    endtask

    // Full descriptor fetch with the DMA model writing the descriptor, a
    // stray beat above the buffer, then returning status err.
    task automatic do_fetch(input string tag, input logic [63:0] exp_src, input logic [3:0] err,
                            input logic [15:0] blen, input logic [63:0] baddr, input int stall);
        logic [127:0] desc;
        logic [127:0] exp_data;
        bit ok;
        desc     = {baddr, 16'h0000, blen, 32'h0000_0000};
        exp_data = (err == 4'd0) ? desc : 128'd0;
        desc_req = 1'b1;
        @(negedge clk);
        desc_req = 1'b0;
        accept_req(tag, exp_src, ok);
        if (!ok) return;
        wr_valid = 2'b11; wr_addr = 24'd0; wr_be = '1; wr_data = desc;
        @(negedge clk);
        check({tag, " wr_done"}, wr_done, 2'b11);
        wr_addr = {12'd1, 12'd1}; wr_data = '1;
        @(negedge clk);
        wr_valid = 2'b00;
        @(negedge clk);
        check({tag, " wr_done gone"}, wr_done, 2'b00);
        sts_valid = 1'b1; sts_error = err;
        @(negedge clk);
        sts_valid = 1'b0; sts_error = 4'd0;
        check({tag, " tvalid"}, tvalid, 1'b1);
        check({tag, " tuser"}, tuser, (err != 4'd0));
        check({tag, " tdata"}, tdata, exp_data);
        check({tag, " tlast"}, tlast, 1'b1);
        if (err == 4'd0) check({tag, " buf len"}, tdata[47:32], blen);
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            check({tag, " stall hold"}, {tvalid, tuser, tdata}, {1'b1, 1'b1, 128'd0});
        end
        tready = 1'b1;
        @(negedge clk);
        tready = 1'b0;
        check({tag, " tvalid drop"}, tvalid, 1'b0);
        if (err == 4'd0) exp_cons = exp_cons + 1'b1;
        check({tag, " cons_ptr"}, cons_ptr, exp_cons);
    endtask

    initial begin
        bit ok;
        // Reset state
        @(negedge clk);
        check("rst tvalid/tuser", {tvalid, tuser}, 2'b00);
        check("rst tdata", tdata, 128'd0);
        check("rst cons_ptr", cons_ptr, 4'd0);
        check("rst req_valid", req_valid, 1'b0);
        check("rst wr_ready", {wr_ready, wr_done}, 4'b0000);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("wr_ready after rst", wr_ready, 2'b11);

        // Empty ring
        enable = 1'b1; prod_ptr = 4'd0;
        do_empty_fail("empty");

        // Three fetches, 16-entry ring
        ring_base = BASE; ring_log_size = 4'd4; prod_ptr = 4'd3;
        do_fetch("f0", BASE + 64'h00, 4'd0, 16'h0800, 64'hAAAA_0000_0000_1000, 0);
        do_fetch("f1", BASE + 64'h10, 4'd0, 16'h0800, 64'hAAAA_0000_0000_2000, 0);
        do_fetch("f2", BASE + 64'h20, 4'd0, 16'h0800, 64'hAAAA_0000_0000_3000, 0);
        check("cons after 3", cons_ptr, 4'd3);

        // 4-entry ring: index 3 then wrap to index 0
        ring_log_size = 4'd2; prod_ptr = 4'd5;
        do_fetch("w0", BASE + 64'h30, 4'd0, 16'h0100, 64'h0000_0000_0000_4000, 0);
        do_fetch("w1", BASE + 64'h00, 4'd0, 16'h0200, 64'h0000_0000_0000_5000, 0);
        check("cons after wrap", cons_ptr, 4'd5);

        // Pointer wrap modulo 2^PTR_W
        ring_log_size = 4'd4; prod_ptr = 4'hF;
        while (exp_cons != 4'hF)
            do_fetch("adv", BASE + (64'(exp_cons) << 4), 4'd0, 16'h0040, 64'h0000_0000_0000_6000, 0);
        prod_ptr = 4'h0;
        do_fetch("ptrwrap", BASE + 64'hF0, 4'd0, 16'h0080, 64'h0000_0000_0000_7000, 0);
        check("cons wrapped", cons_ptr, 4'h0);
        do_empty_fail("empty after wrap");

        // DMA error with a stalled consumer
        prod_ptr = 4'd1;
        do_fetch("dmaerr", BASE, 4'd1, 16'h0800, 64'h0, 10);
`ifdef CNDM_DESC_FETCH_STATS_EN
        check("stat_empty", stat_empty_cnt, 32'd2);
        check("stat_err", stat_err_cnt, 32'd1);
`endif

        // Successful fetch, then reset while waiting on the next status
        do_fetch("pre rst", BASE, 4'd0, 16'h0123, 64'h1111_2222_3333_4444, 0);
        prod_ptr = 4'd2;
        desc_req = 1'b1;
        @(negedge clk);
        desc_req = 1'b0;
        accept_req("rst mid", BASE + 64'h10, ok);
        #2 rst_n = 1'b0;
        #1;
        check("async rst cons", cons_ptr, 4'd0);
        check("async rst tdata", tdata, 128'd0);
        check("async rst valids", {tvalid, tuser, req_valid, wr_ready}, 5'd0);
        @(negedge clk);
        rst_n = 1'b1;
        exp_cons = '0;
        repeat (4) @(negedge clk);
        sts_valid = 1'b1;
        @(negedge clk);
        sts_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("late sts ignored", {tvalid, req_valid}, 2'b00);
        check("late sts cons", cons_ptr, 4'd0);

        // Normal operation resumes after reset
        prod_ptr = 4'd1;
        do_fetch("post rst", BASE, 4'd0, 16'h0800, 64'h0000_0000_0000_9000, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
